// File: rtl/fft_pkg.sv
// Shared constants and phase type for the 128-point streaming FFT stages.
package fft_pkg;

  localparam int BW      = 16;
  localparam int FFT_LEN = 128;
  localparam int HALF    = 64;
  localparam int CNT_W   = 6;
  localparam int SCNT_W  = 7;

  typedef enum logic {
    PHASE_A = 1'b0,
    PHASE_B = 1'b1
  } phase_t;

  // The top bit of the in-frame sample counter selects the butterfly phase.
  function automatic phase_t phase_of(input logic [SCNT_W-1:0] s);
    return phase_t'(s[SCNT_W-1]);
  endfunction

endpackage

// File: rtl/sdf_bf_stage1_if.sv
// Streaming sample bus into the first SDF butterfly and its output toward the twiddle multiplier.
interface sdf_bf_stage1_if #(parameter int BW = fft_pkg::BW);

  logic                          in_valid;
  logic signed [BW-1:0]          In_Real;
  logic signed [BW-1:0]          In_Imag;
  logic                          out_valid;
  logic signed [BW:0]            Out_Real;
  logic signed [BW:0]            Out_Imag;
  logic [fft_pkg::CNT_W-1:0]     cnt;
  logic                          out_sop;

  modport master (
    output in_valid, In_Real, In_Imag,
    input  out_valid, Out_Real, Out_Imag, cnt, out_sop
  );

  modport slave (
    input  in_valid, In_Real, In_Imag,
    output out_valid, Out_Real, Out_Imag, cnt, out_sop
  );

endinterface

// File: rtl/sdf_delay_line.sv
// Enable-gated circular buffer of N words; the head word is read in the same cycle it is overwritten.
module sdf_delay_line #(
  parameter int N = 64,
  parameter int W = 34
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  localparam int AW = $clog2(N);

  logic [W-1:0]  mem [N];
  logic [AW-1:0] ptr;

  assign dout = mem[ptr];

  // Contents are deliberately left unreset; the butterfly masks them until primed.
  always_ff @(posedge clk) begin
    if (en) mem[ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == AW'(N - 1)) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/sdf_bf_stage1.sv
// First radix-2 DIF SDF butterfly: sums during phase B, stored differences replayed during the next phase A.
module sdf_bf_stage1
  import fft_pkg::*;
#(
  parameter int BW = fft_pkg::BW,
  parameter int N  = fft_pkg::HALF
) (
  input  logic               clk,
  input  logic               rst,
  sdf_bf_stage1_if.slave     bus
);

  logic [SCNT_W-1:0]  s;
  logic               primed;
  phase_t             phase;

  logic signed [BW:0] in_re;
  logic signed [BW:0] in_im;
  logic signed [BW:0] d_re;
  logic signed [BW:0] d_im;
  logic signed [BW:0] nxt_re;
  logic signed [BW:0] nxt_im;
  logic [CNT_W-1:0]   nxt_cnt;
  logic [2*BW+1:0]    wr_data;
  logic [2*BW+1:0]    rd_data;

  logic               ov;
  logic               osop;
  logic signed [BW:0] ore;
  logic signed [BW:0] oim;
  logic [CNT_W-1:0]   ocnt;

  sdf_delay_line #(
    .N (N),
    .W (2 * (BW + 1))
  ) u_dl (
    .clk  (clk),
    .rst  (rst),
    .en   (bus.in_valid),
    .din  (wr_data),
    .dout (rd_data)
  );

  // Phase A forwards the stored difference and parks the new sample; phase B forms sum and difference.
  always_comb begin
    in_re   = {bus.In_Real[BW-1], bus.In_Real};
    in_im   = {bus.In_Imag[BW-1], bus.In_Imag};
    d_re    = rd_data[2*BW+1:BW+1];
    d_im    = rd_data[BW:0];
    phase   = phase_of(s);
    wr_data = {in_re, in_im};
    nxt_re  = d_re;
    nxt_im  = d_im;
    nxt_cnt = s[CNT_W-1:0];
    if (phase == PHASE_B) begin
      nxt_re  = d_re + in_re;
      nxt_im  = d_im + in_im;
      wr_data = {d_re - in_re, d_im - in_im};
      nxt_cnt = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s      <= '0;
      primed <= 1'b0;
      ov     <= 1'b0;
      osop   <= 1'b0;
      ore    <= '0;
      oim    <= '0;
      ocnt   <= '0;
    end else begin
      ov   <= bus.in_valid & ((phase == PHASE_B) | primed);
      osop <= bus.in_valid & (s == SCNT_W'(N));
      if (bus.in_valid) begin
        s    <= s + 1'b1;
        ore  <= nxt_re;
        oim  <= nxt_im;
        ocnt <= nxt_cnt;
        if (phase == PHASE_B) primed <= 1'b1;
      end
    end
  end

  assign bus.out_valid = ov;
  assign bus.out_sop   = osop;
  assign bus.Out_Real  = ore;
  assign bus.Out_Imag  = oim;
  assign bus.cnt       = ocnt;

endmodule

// File: tb/tb_sdf_bf_stage1.sv
// Randomised and directed bench for sdf_bf_stage1 against a frame-level butterfly model.
module tb_sdf_bf_stage1;
  import fft_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sdf_bf_stage1_if #(.BW(BW)) bus ();

  sdf_bf_stage1 #(.BW(BW), .N(HALF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Frame-level model: whole input frames are kept and outputs derived from x[n] +/- x[n+64].
  int k;
  bit primed_m;
  int cur_re [FFT_LEN];
  int cur_im [FFT_LEN];
  int prev_re [FFT_LEN];
  int prev_im [FFT_LEN];
  bit exp_valid;
  bit exp_sop;
  int exp_re;
  int exp_im;
  int exp_cnt;
  bit data_known;

  task automatic check_val(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_output();
    check_val("out_valid", int'(bus.out_valid), int'(exp_valid));
    check_val("out_sop", int'(bus.out_sop), int'(exp_sop));
    check_val("cnt", int'(bus.cnt), exp_cnt);
    if (data_known) begin
      check_val("Out_Real", int'(bus.Out_Real), exp_re);
      check_val("Out_Imag", int'(bus.Out_Imag), exp_im);
    end
  endtask

  task automatic model_reset();
    k          = 0;
    primed_m   = 1'b0;
    exp_valid  = 1'b0;
    exp_sop    = 1'b0;
    exp_re     = 0;
    exp_im     = 0;
    exp_cnt    = 0;
    data_known = 1'b1;
  endtask

  task automatic model_accept(input int re, input int im);
    exp_sop = 1'b0;
    if (k < HALF) begin
      exp_cnt = k;
      if (primed_m) begin
        exp_valid  = 1'b1;
        exp_re     = prev_re[k] - prev_re[k + HALF];
        exp_im     = prev_im[k] - prev_im[k + HALF];
        data_known = 1'b1;
      end else begin
        exp_valid  = 1'b0;
        data_known = 1'b0;
      end
    end else begin
      exp_valid  = 1'b1;
      exp_cnt    = 0;
      exp_sop    = (k == HALF);
      exp_re     = cur_re[k - HALF] + re;
      exp_im     = cur_im[k - HALF] + im;
      data_known = 1'b1;
    end
    cur_re[k] = re;
    cur_im[k] = im;
    k++;
    if (k == FFT_LEN) begin
      for (int i = 0; i < FFT_LEN; i++) begin
        prev_re[i] = cur_re[i];
        prev_im[i] = cur_im[i];
      end
      k        = 0;
      primed_m = 1'b1;
    end
  endtask

  task automatic apply_stimulus(input bit v, input int re, input int im);
    @(negedge clk);
    bus.in_valid = v;
    bus.In_Real  = 16'(re);
    bus.In_Imag  = 16'(im);
    if (v) begin
      model_accept(int'($signed(16'(re))), int'($signed(16'(im))));
    end else begin
      exp_valid = 1'b0;
      exp_sop   = 1'b0;
    end
    @(posedge clk);
    #1;
    check_output();
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < cycles; i++) begin
      bus.in_valid = 1'($urandom);
      bus.In_Real  = 16'($urandom);
      bus.In_Imag  = 16'($urandom);
      #1;
      check_output();
      @(negedge clk);
    end
    rst          = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  // Accepts one sample, optionally preceded by a random idle cycle.
  task automatic feed(input int re, input int im, input bit gaps);
    if (gaps && $urandom_range(0, 3) == 0) begin
      apply_stimulus(1'b0, int'($urandom), int'($urandom));
    end
    apply_stimulus(1'b1, re, im);
  endtask

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.In_Real  = '0;
    bus.In_Imag  = '0;
    model_reset();

    $display("[TB] reset with random inputs");
    apply_reset(4);

    $display("[TB] impulse frame");
    apply_stimulus(1'b1, 1000, 0);
    for (int i = 1; i < FFT_LEN; i++) apply_stimulus(1'b1, 0, 0);
    for (int i = 0; i < FFT_LEN; i++) apply_stimulus(1'b1, 0, 0);

    $display("[TB] constant frame");
    apply_reset(2);
    for (int i = 0; i < FFT_LEN; i++) apply_stimulus(1'b1, 100, -50);
    for (int i = 0; i < HALF; i++) apply_stimulus(1'b1, 0, 0);

    $display("[TB] full-scale frame");
    apply_reset(2);
    for (int i = 0; i < FFT_LEN; i++) apply_stimulus(1'b1, (i < HALF) ? 32767 : -32768, 0);
    for (int i = 0; i < HALF; i++) apply_stimulus(1'b1, 0, 0);

    $display("[TB] bubbles and random data");
    apply_reset(2);
    for (int i = 0; i < FFT_LEN; i++) feed(100, -50, 1'b1);
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < FFT_LEN; i++) feed(int'($urandom), int'($urandom), 1'b1);
    end
    for (int i = 0; i < HALF; i++) feed(0, 0, 1'b1);

    $display("[TB] reset mid-stream");
    apply_reset(2);
    for (int i = 0; i < FFT_LEN + 40; i++) feed(int'($urandom), int'($urandom), 1'b0);
    apply_reset(1);
    for (int i = 0; i < FFT_LEN; i++) feed(int'($urandom), int'($urandom), 1'b1);
    for (int i = 0; i < HALF; i++) feed(0, 0, 1'b0);
    apply_stimulus(1'b0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
